ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 46 ++++
 rtl/ram_arbiter_rr.sv | 50 +++++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the dual round-robin RAM arbiter.
//   - MaxPorts / IdxWidth: upper bound on requesters and the port-index width
//   - clog2: constant-friendly ceiling log2
//   - rr_pick_t / rr_search: round-robin winner search starting after a pointer
package ram_arb_pkg;

    localparam int MaxPorts = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a port index, sized for the largest supported port count.
    localparam int IdxWidth = clog2(MaxPorts);

    typedef struct packed {
        logic                found;
        logic [IdxWidth-1:0] idx;
    } rr_pick_t;

    // First requesting port found when scanning ptr+1, ptr+2, ... modulo
    // num_ports. Requests at or above num_ports are never considered.
    function automatic rr_pick_t rr_search(input logic [MaxPorts-1:0] req,
                                           input logic [IdxWidth-1:0] ptr,
                                           input int                  num_ports);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= MaxPorts; k++) begin
            cand = (int'(ptr) + k) % num_ports;
            if (k <= num_ports && !pick.found && req[cand[IdxWidth-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[IdxWidth-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// rr_arbiter: single round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request vector, one bit per port
//   enable      allows the candidate to be granted this cycle (0 = withhold)
//   grant       one-hot grant, zero when nothing granted
//   idx         index of the round-robin candidate (valid when grant != 0)
// The pointer resets to NumPorts-1 so port 0 has first priority, and only
// moves when a grant is actually issued.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NumPorts = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumPorts-1:0] req,
    input  logic                enable,
    output logic [NumPorts-1:0] grant,
    output logic [IdxWidth-1:0] idx
);

    logic [IdxWidth-1:0] ptr;
    logic [MaxPorts-1:0] req_ext;
    rr_pick_t            pick;

    assign req_ext = MaxPorts'(req);
    assign pick    = rr_search(req_ext, ptr, NumPorts);
    assign idx     = pick.idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (enable && pick.found && pick.idx == IdxWidth'(i)) begin
                grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (!rst_n) begin
            ptr <= IdxWidth'(NumPorts - 1);
        end else if (enable && pick.found) begin
            ptr <= pick.idx;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one dual-port RAM (one write port, one read port)
// among NumPorts requesters using two independent round-robin arbiters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_write             per-port request and direction (1 = write)
//   req_addr/req_wdata/req_mask     packed per-port address, data, mask (1 = keep bit)
//   req_ready                       combinational accept, one write + one read max
//   resp_valid/resp_data            one-hot read response, one cycle after read accept
//   ram_write_*                     RAM write port, issued in the accept cycle
//   ram_read_en/addr, ram_read_data RAM read port; data registered by the RAM
// Optional macro RAM_ARB_RAW_STALL_EN: a read that targets the address being
// written in the same cycle is withheld and re-arbitrated the next cycle.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int DataWidth = 16,
    parameter int AddrWidth = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumPorts-1:0]           req_valid,
    input  logic [NumPorts-1:0]           req_write,
    input  logic [NumPorts*AddrWidth-1:0] req_addr,
    input  logic [NumPorts*DataWidth-1:0] req_wdata,
    input  logic [NumPorts*DataWidth-1:0] req_mask,
    output logic [NumPorts-1:0]           req_ready,
    output logic [NumPorts-1:0]           resp_valid,
    output logic [DataWidth-1:0]          resp_data,
    output logic                          ram_write_en,
    output logic [AddrWidth-1:0]          ram_write_addr,
    output logic [DataWidth-1:0]          ram_write_data,
    output logic [DataWidth-1:0]          ram_write_mask,
    output logic                          ram_read_en,
    output logic [AddrWidth-1:0]          ram_read_addr,
    input  logic [DataWidth-1:0]          ram_read_data
);

    logic [NumPorts-1:0]  w_req;
    logic [NumPorts-1:0]  r_req;
    logic [NumPorts-1:0]  w_grant;
    logic [NumPorts-1:0]  r_grant;
    logic [IdxWidth-1:0]  w_idx;
    logic [IdxWidth-1:0]  r_idx;
    logic                 w_issue;
    logic                 r_issue;
    logic                 r_enable;
    logic [AddrWidth-1:0] w_addr;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] w_data;
    logic [DataWidth-1:0] w_mask;
    logic                 rd_pending;
    logic [IdxWidth-1:0]  rd_idx;

    assign w_req = req_valid & req_write;
    assign r_req = req_valid & ~req_write;

    // Fields of each arbiter's candidate. The index is always below NumPorts.
    always_comb begin
        w_addr = req_addr[int'(w_idx)*AddrWidth +: AddrWidth];
        w_data = req_wdata[int'(w_idx)*DataWidth +: DataWidth];
        w_mask = req_mask[int'(w_idx)*DataWidth +: DataWidth];
        r_addr = req_addr[int'(r_idx)*AddrWidth +: AddrWidth];
    end

`ifdef RAM_ARB_RAW_STALL_EN
    // A pending read implies a read candidate exists; if it collides with the
    // write being issued, hold the read so it sees the new data next cycle.
    assign r_enable = rst_n & ~(w_issue & (|r_req) & (w_addr == r_addr));
`else
    assign r_enable = rst_n;
`endif

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    rr_arbiter #(.NumPorts(NumPorts)) u_write_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (w_req),
        .enable (rst_n),
        .grant  (w_grant),
        .idx    (w_idx)
    );

    rr_arbiter #(.NumPorts(NumPorts)) u_read_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (r_req),
        .enable (r_enable),
        .grant  (r_grant),
        .idx    (r_idx)
    );

    assign w_issue   = |w_grant;
    assign r_issue   = |r_grant;
    assign req_ready = w_grant | r_grant;

    assign ram_write_en   = w_issue;
    assign ram_write_addr = w_issue ? w_addr : '0;
    assign ram_write_data = w_issue ? w_data : '0;
    assign ram_write_mask = w_issue ? w_mask : '0;
    assign ram_read_en    = r_issue;
    assign ram_read_addr  = r_issue ? r_addr : '0;

    // Remember which port owns the read data the RAM returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_idx     <= '0;
        end else begin
            rd_pending <= r_issue;
            if (r_issue) begin
                rd_idx <= r_idx;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (rd_pending && rd_idx == IdxWidth'(i)) begin
                resp_valid[i] = 1'b1;
            end
        end
    end

    assign resp_data = rd_pending ? ram_read_data : '0;

endmodule
